// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode of each fetched word into an output FIFO
// with valid/ready handshakes, synchronous flush and saturating statistics counters.
module decode_stage #(
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int ENABLE_M   = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_instr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [5:0]        out_op,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [31:0]       out_imm,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  instr_count,
  output logic [CNT_W-1:0]  illegal_count
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_FW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_FW-1:0] FULL_CNT = CNT_FW'(FIFO_DEPTH);
  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef enum logic [5:0] {
    OP_ILLEGAL = 6'd0,
    OP_ADD  = 6'd1,  OP_SUB  = 6'd2,  OP_AND  = 6'd3,  OP_OR    = 6'd4,  OP_XOR  = 6'd5,
    OP_SLL  = 6'd6,  OP_SRL  = 6'd7,  OP_SRA  = 6'd8,  OP_SLT   = 6'd9,  OP_SLTU = 6'd10,
    OP_ADDI = 6'd11, OP_ANDI = 6'd12, OP_ORI  = 6'd13, OP_XORI  = 6'd14, OP_SLLI = 6'd15,
    OP_SRLI = 6'd16, OP_SRAI = 6'd17, OP_SLTI = 6'd18, OP_SLTIU = 6'd19,
    OP_LW   = 6'd20, OP_SW   = 6'd21, OP_BEQ  = 6'd22, OP_BNE   = 6'd23, OP_LUI  = 6'd24,
    OP_JAL  = 6'd25, OP_MUL  = 6'd26
  } op_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [5:0]        op;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [31:0]       imm;
    logic              illegal;
  } entry_t;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  op_e         dec_op;
  logic [31:0] dec_imm;
  logic        dec_illegal;
  entry_t      new_entry;
  entry_t      head;

  entry_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_FW-1:0]  count_q, count_d;
  logic               init_q;
  logic [CNT_W-1:0]   instr_cnt_q, illegal_cnt_q;
  logic               push, pop;

  assign opc    = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
  assign imm_sh = {27'b0, in_instr[24:20]};

  always_comb begin
    dec_op = OP_ILLEGAL;
    case (opc)
      7'b0110011: begin
        case (f3)
          3'b000: begin
            if (f7 == F7_ZERO)                        dec_op = OP_ADD;
            else if (f7 == F7_ALT)                    dec_op = OP_SUB;
            else if ((ENABLE_M != 0) && f7 == F7_MUL) dec_op = OP_MUL;
            else                                      dec_op = OP_ILLEGAL;
          end
          3'b001:  dec_op = (f7 == F7_ZERO) ? OP_SLL  : OP_ILLEGAL;
          3'b010:  dec_op = (f7 == F7_ZERO) ? OP_SLT  : OP_ILLEGAL;
          3'b011:  dec_op = (f7 == F7_ZERO) ? OP_SLTU : OP_ILLEGAL;
          3'b100:  dec_op = (f7 == F7_ZERO) ? OP_XOR  : OP_ILLEGAL;
          3'b101:  dec_op = (f7 == F7_ZERO) ? OP_SRL  : (f7 == F7_ALT) ? OP_SRA : OP_ILLEGAL;
          3'b110:  dec_op = (f7 == F7_ZERO) ? OP_OR   : OP_ILLEGAL;
          default: dec_op = (f7 == F7_ZERO) ? OP_AND  : OP_ILLEGAL;
        endcase
      end
      7'b0010011: begin
        case (f3)
          3'b000:  dec_op = OP_ADDI;
          3'b001:  dec_op = (f7 == F7_ZERO) ? OP_SLLI : OP_ILLEGAL;
          3'b010:  dec_op = OP_SLTI;
          3'b011:  dec_op = OP_SLTIU;
          3'b100:  dec_op = OP_XORI;
          3'b101:  dec_op = (f7 == F7_ZERO) ? OP_SRLI : (f7 == F7_ALT) ? OP_SRAI : OP_ILLEGAL;
          3'b110:  dec_op = OP_ORI;
          default: dec_op = OP_ANDI;
        endcase
      end
      7'b0000011: dec_op = (f3 == 3'b010) ? OP_LW : OP_ILLEGAL;
      7'b0100011: dec_op = (f3 == 3'b010) ? OP_SW : OP_ILLEGAL;
      7'b1100011: dec_op = (f3 == 3'b000) ? OP_BEQ : (f3 == 3'b001) ? OP_BNE : OP_ILLEGAL;
      7'b0110111: dec_op = OP_LUI;
      7'b1101111: dec_op = OP_JAL;
      default:    dec_op = OP_ILLEGAL;
    endcase
  end

  // Immediate format is chosen from the decoded op so illegal words carry a zero immediate.
  always_comb begin
    dec_imm = '0;
    case (dec_op)
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU, OP_LW: dec_imm = imm_i;
      OP_SLLI, OP_SRLI, OP_SRAI: dec_imm = imm_sh;
      OP_SW:                     dec_imm = imm_s;
      OP_BEQ, OP_BNE:            dec_imm = imm_b;
      OP_LUI:                    dec_imm = imm_u;
      OP_JAL:                    dec_imm = imm_j;
      default:                   dec_imm = '0;
    endcase
  end

  assign dec_illegal = (dec_op == OP_ILLEGAL);
  assign new_entry   = '{addr: in_addr, op: dec_op, rd: in_instr[11:7], rs1: in_instr[19:15],
                         rs2: in_instr[24:20], imm: dec_imm, illegal: dec_illegal};

  assign in_ready  = init_q && (count_q < FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      init_q        <= 1'b0;
      instr_cnt_q   <= '0;
      illegal_cnt_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      init_q   <= 1'b1;
      if (push && instr_cnt_q != '1)
        instr_cnt_q <= instr_cnt_q + 1'b1;
      if (push && dec_illegal && illegal_cnt_q != '1)
        illegal_cnt_q <= illegal_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= new_entry;
  end

  assign head          = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_addr      = head.addr;
  assign out_op        = head.op;
  assign out_rd        = head.rd;
  assign out_rs1       = head.rs1;
  assign out_rs2       = head.rs2;
  assign out_imm       = head.imm;
  assign out_illegal   = head.illegal;
  assign instr_count   = instr_cnt_q;
  assign illegal_count = illegal_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed stimulus, scoreboard of expected decodes checked at pop.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready, out_illegal;
  logic [31:0] in_addr, in_instr, out_addr, out_imm;
  logic [5:0]  out_op;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [15:0] instr_count, illegal_count;

  logic        in_valid2, in_ready2, out_valid2, out_illegal2;
  logic [31:0] in_instr2, out_addr2, out_imm2;
  logic [5:0]  out_op2;
  logic [4:0]  out_rd2, out_rs12, out_rs22;
  logic [3:0]  instr_count2, illegal_count2;

  typedef struct {
    logic [31:0] addr;
    logic [5:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  int          n_vec = 0;
  int          n_fail = 0;
  logic [15:0] exp_icnt = '0;
  logic [15:0] exp_lcnt = '0;
  logic [31:0] next_addr = 32'h1000;

  always #5 clk = ~clk;

  decode_stage #(.ADDR_W(32), .FIFO_DEPTH(2), .ENABLE_M(0), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_instr(in_instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_op(out_op), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .out_illegal(out_illegal), .instr_count(instr_count),
    .illegal_count(illegal_count)
  );

  decode_stage #(.ADDR_W(32), .FIFO_DEPTH(3), .ENABLE_M(1), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .in_addr(32'h2000),
    .in_instr(in_instr2), .flush(1'b0), .out_valid(out_valid2), .out_ready(1'b1),
    .out_addr(out_addr2), .out_op(out_op2), .out_rd(out_rd2), .out_rs1(out_rs12),
    .out_rs2(out_rs22), .out_imm(out_imm2), .out_illegal(out_illegal2),
    .instr_count(instr_count2), .illegal_count(illegal_count2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on accept, compare head on pop; flush voids both.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!flush && out_valid && out_ready) begin
        if (q.size() == 0) check("spurious_out_valid", {31'b0, out_valid}, 32'd0);
        else begin
          exp_t e;
          e = q.pop_front();
          check("out_addr", out_addr, e.addr);
          check("out_op", {26'b0, out_op}, {26'b0, e.op});
          check("out_rd", {27'b0, out_rd}, {27'b0, e.rd});
          check("out_rs1", {27'b0, out_rs1}, {27'b0, e.rs1});
          check("out_rs2", {27'b0, out_rs2}, {27'b0, e.rs2});
          check("out_illegal", {31'b0, out_illegal}, {31'b0, e.ill});
          if (!e.ill) check("out_imm", out_imm, e.imm);
        end
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) begin
        q.push_back(cur);
        if (exp_icnt != 16'hFFFF) exp_icnt++;
        if (cur.ill && exp_lcnt != 16'hFFFF) exp_lcnt++;
      end
    end
  end

  task automatic send(input logic [31:0] instr, input logic [5:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    bit ok;
    ok = 1'b0;
    cur = '{addr: next_addr, op: op, rd: rd, rs1: rs1, rs2: rs2, imm: imm, ill: (op == 6'd0)};
    in_addr  = next_addr;
    in_instr = instr;
    in_valid = 1'b1;
    next_addr += 32'd4;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && q.size() != 0; k++) @(posedge clk);
    #1;
    check("drain_queue_empty", q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_addr = '0; in_instr = '0; in_valid2 = 1'b0; in_instr2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_instr_count", {16'b0, instr_count}, 32'd0);
    check("rst_out_op", {26'b0, out_op}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", {31'b0, in_ready}, 32'd1);

    // SUB, then first-cycle visibility and counter
    send(32'h40208033, 6'd2, 5'd0, 5'd1, 5'd2, 32'h0);
    check("latency_out_valid", {31'b0, out_valid}, 32'd1);
    check("instr_count_1", {16'b0, instr_count}, 32'd1);

    send(32'hFFF00093, 6'd11, 5'd1, 5'd0, 5'd31, 32'hFFFFFFFF);
    send(32'h000010B7, 6'd24, 5'd1, 5'd0, 5'd0, 32'h00001000);
    send(32'h002081B3, 6'd1, 5'd3, 5'd1, 5'd2, 32'h0);
    send(32'h4020D1B3, 6'd8, 5'd3, 5'd1, 5'd2, 32'h0);
    send(32'h0020F1B3, 6'd3, 5'd3, 5'd1, 5'd2, 32'h0);
    send(32'h40315093, 6'd17, 5'd1, 5'd2, 5'd3, 32'h3);
    send(32'hFE20AE23, 6'd21, 5'd28, 5'd1, 5'd2, 32'hFFFFFFFC);
    send(32'hFE208CE3, 6'd22, 5'd25, 5'd1, 5'd2, 32'hFFFFFFF8);
    send(32'h00001263, 6'd23, 5'd4, 5'd0, 5'd0, 32'h4);
    send(32'h001000EF, 6'd25, 5'd1, 5'd0, 5'd1, 32'h800);
    send(32'h01032283, 6'd20, 5'd5, 5'd6, 5'd16, 32'h10);
    send(32'hFFF13093, 6'd19, 5'd1, 5'd2, 5'd31, 32'hFFFFFFFF);
    send(32'h00000000, 6'd0, 5'd0, 5'd0, 5'd0, 32'h0);
    send(32'h40209093, 6'd0, 5'd1, 5'd1, 5'd2, 32'h0);
    send(32'h4020F1B3, 6'd0, 5'd3, 5'd1, 5'd2, 32'h0);
    drain();

    // Backpressure: two accepts fill the FIFO, the third is held with stable head
    out_ready = 1'b0;
    send(32'h002081B3, 6'd1, 5'd3, 5'd1, 5'd2, 32'h0);
    send(32'h0020F1B3, 6'd3, 5'd3, 5'd1, 5'd2, 32'h0);
    check("full_in_ready", {31'b0, in_ready}, 32'd0);
    in_instr = 32'h000010B7;
    in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("held_in_ready", {31'b0, in_ready}, 32'd0);
      check("held_head_addr", out_addr, q[0].addr);
      check("held_head_op", {26'b0, out_op}, 32'd1);
    end
    out_ready = 1'b1;
    send(32'h000010B7, 6'd24, 5'd1, 5'd0, 5'd0, 32'h00001000);
    drain();

    // MUL is illegal without ENABLE_M
    send(32'h02208033, 6'd0, 5'd0, 5'd1, 5'd2, 32'h0);
    drain();
    check("illegal_count", {16'b0, illegal_count}, {16'b0, exp_lcnt});
    check("instr_count", {16'b0, instr_count}, {16'b0, exp_icnt});

    // Flush on a full FIFO with a simultaneous incoming instruction
    out_ready = 1'b0;
    send(32'h002081B3, 6'd1, 5'd3, 5'd1, 5'd2, 32'h0);
    send(32'h4020D1B3, 6'd8, 5'd3, 5'd1, 5'd2, 32'h0);
    in_instr = 32'hFFF00093;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", {31'b0, out_valid}, 32'd0);
    check("flush_in_ready", {31'b0, in_ready}, 32'd1);
    check("flush_instr_count", {16'b0, instr_count}, {16'b0, exp_icnt});
    check("flush_out_imm_zero", out_imm, 32'd0);
    out_ready = 1'b1;

    // Asynchronous reset between edges while entries are buffered
    out_ready = 1'b0;
    send(32'h002081B3, 6'd1, 5'd3, 5'd1, 5'd2, 32'h0);
    send(32'h00000000, 6'd0, 5'd0, 5'd0, 5'd0, 32'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("async_rst_instr_count", {16'b0, instr_count}, 32'd0);
    check("async_rst_illegal_count", {16'b0, illegal_count}, 32'd0);
    check("async_rst_in_ready", {31'b0, in_ready}, 32'd0);
    q.delete();
    exp_icnt = '0;
    exp_lcnt = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h000010B7, 6'd24, 5'd1, 5'd0, 5'd0, 32'h00001000);
    drain();
    check("post_rst_instr_count", {16'b0, instr_count}, 32'd1);

    // ENABLE_M=1 instance: MUL decodes; 4-bit counters saturate
    in_instr2 = 32'h02208033;
    in_valid2 = 1'b1;
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    check("m_out_valid", {31'b0, out_valid2}, 32'd1);
    check("m_out_op", {26'b0, out_op2}, 32'd26);
    check("m_out_illegal", {31'b0, out_illegal2}, 32'd0);
    check("m_out_rs2", {27'b0, out_rs22}, 32'd2);
    in_instr2 = 32'h00000000;
    in_valid2 = 1'b1;
    repeat (13) @(posedge clk);
    #1;
    check("sat_instr_14", {28'b0, instr_count2}, 32'd14);
    check("sat_illegal_13", {28'b0, illegal_count2}, 32'd13);
    repeat (3) @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    check("sat_instr_hold", {28'b0, instr_count2}, 32'd15);
    check("sat_illegal_hold", {28'b0, illegal_count2}, 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
